// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;
  localparam int PC_W_DEF = 16;
  localparam int INSTR_W  = 16;
  localparam int CNT_W    = 32;
  localparam int PC_INC   = 2;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0]        BUBBLE_PC = 16'h0000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_hold_buf.sv
// One-entry instruction holding register: keeps a returned instruction while the
// pipeline is stalled. Built bit-by-bit from plain D flops with load and clear.
module fetch_hold_buf
  import fetch_stage_pkg::*;
#(
  parameter int W = INSTR_W
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);
  logic valid_q;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic bit_q;
    always_ff @(posedge clk) begin
      if (!rst_ni || clear_i) bit_q <= 1'b0;
      else if (load_i)        bit_q <= data_i[gi];
    end
    assign data_o[gi] = bit_q;
  end

  // Clear wins over load so a redirect can never leave a stale entry marked valid.
  always_ff @(posedge clk) begin
    if (!rst_ni || clear_i) valid_q <= 1'b0;
    else if (load_i)        valid_q <= 1'b1;
  end

  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, stalling i-memory handshake, redirects, halt and IF/ID.
// Define FETCH_PERF_CNT_EN to add the fetchCount / missCycles performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazStall,
  input  logic               memStall,
  input  logic               doBranch,
  input  logic [PC_W-1:0]    branchTarget,
  input  logic               halt,
  output logic               imemRd,
  output logic [PC_W-1:0]    imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               imemStall,
  input  logic               imemDone,
  output logic [INSTR_W-1:0] instrOut,
  output logic [PC_W-1:0]    nextPcOut,
  output logic               fetchStall,
  output logic               err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   fetchCount,
  output logic [CNT_W-1:0]   missCycles
`endif
);
  fetch_state_e state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, npc_q, npc_d, pc_inc;
  logic [INSTR_W-1:0] instr_q, instr_d, del_instr, buf_data;
  logic err_q, err_d, hpend_q, hpend_d;
  logic stall, req, deliver, bubble, buf_load, buf_clear, buf_valid;

  assign stall  = hazStall | memStall;
  assign pc_inc = pc_q + PC_W'(PC_INC);
  assign req    = rst && (state_q == ST_FETCH) && !stall && !halt && !pc_q[0];

  fetch_hold_buf #(.W(INSTR_W)) u_hold_buf (
    .clk     (clk),
    .rst_ni  (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (imemData),
    .data_o  (buf_data),
    .valid_o (buf_valid)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    npc_d     = npc_q;
    err_d     = err_q;
    hpend_d   = hpend_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    deliver   = 1'b0;
    bubble    = 1'b0;
    del_instr = imemData;
    if (rst) begin
      unique case (state_q)
        ST_FETCH: begin
          if (doBranch) begin
            pc_d      = branchTarget;
            bubble    = 1'b1;
            buf_clear = 1'b1;
            // Only a miss issued this cycle leaves a response still to come.
            if (req && !imemDone && imemStall) state_d = ST_DRAIN;
          end else if (halt) begin
            bubble  = 1'b1;
            state_d = ST_HALTED;
          end else if (stall) begin
            // hold pc and IF/ID
          end else if (pc_q[0]) begin
            err_d   = 1'b1;
            bubble  = 1'b1;
            state_d = ST_HALTED;
          end else if (imemDone) begin
            deliver = 1'b1;
          end else begin
            bubble = 1'b1;
            if (imemStall) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (doBranch) begin
            pc_d      = branchTarget;
            bubble    = 1'b1;
            buf_clear = 1'b1;
            state_d   = imemDone ? ST_FETCH : ST_DRAIN;
          end else if (halt) begin
            bubble = 1'b1;
            if (imemDone) state_d = ST_HALTED;
            else begin
              hpend_d = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (imemDone) begin
            if (stall) begin
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end else begin
              deliver = 1'b1;
              state_d = ST_FETCH;
            end
          end else if (!stall) begin
            bubble = 1'b1;
          end
        end
        ST_HOLD: begin
          if (doBranch) begin
            pc_d      = branchTarget;
            bubble    = 1'b1;
            buf_clear = 1'b1;
            state_d   = ST_FETCH;
          end else if (halt) begin
            bubble    = 1'b1;
            buf_clear = 1'b1;
            state_d   = ST_HALTED;
          end else if (!stall) begin
            buf_clear = 1'b1;
            state_d   = ST_FETCH;
            if (buf_valid) begin
              deliver   = 1'b1;
              del_instr = buf_data;
            end
          end
        end
        ST_DRAIN: begin
          bubble = 1'b1;
          if (doBranch) pc_d = branchTarget;
          else if (halt) hpend_d = 1'b1;
          if (imemDone) state_d = (hpend_q || (halt && !doBranch)) ? ST_HALTED : ST_FETCH;
        end
        default: bubble = 1'b1;
      endcase
    end
    if (deliver) begin
      instr_d = del_instr;
      npc_d   = pc_inc;
      pc_d    = pc_inc;
    end
    if (bubble) begin
      instr_d = NOP_INSTR;
      npc_d   = PC_W'(BUBBLE_PC);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      npc_q   <= PC_W'(BUBBLE_PC);
      err_q   <= 1'b0;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      err_q   <= err_d;
      hpend_q <= hpend_d;
    end
  end

  assign imemRd     = req;
  assign imemAddr   = pc_q;
  assign instrOut   = instr_q;
  assign nextPcOut  = npc_q;
  assign fetchStall = !deliver;
  assign err        = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      if (deliver && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign fetchCount = fetch_cnt_q;
  assign missCycles = miss_cnt_q;
`endif
endmodule
